// File: rtl/mmcm_rst_seq.sv
// mmcm_rst_seq
//   Reset sequencer and lock supervisor for an MMCM. Runs on a free-running
//   reference clock. It pulses the MMCM reset and waits for a debounced lock.
//   It then releases the staged system resets one stage at a time, index 0
//   first. Any lock drop after release has begun restarts the whole sequence.
//
//   Optional feature macro: MMCM_RST_SEQ_TIMEOUT_EN
//     defined   : WAIT_LOCK gives up after LOCK_TIMEOUT_CYCLES, re-pulses the
//                 MMCM reset and bumps retry_cnt (saturating at 255)
//     undefined : WAIT_LOCK waits indefinitely, retry_cnt is tied to 0
//
// Ports
//   clk_in     in   free-running reference clock (not an MMCM output)
//   rst_in     in   synchronous active-high reset
//   mmcm_lock  in   MMCM LOCKED, asynchronous, double-flopped internally
//   mmcm_rst   out  MMCM RST pin
//   rst_out    out  [NUM_STAGES] staged active-high resets
//   sys_ready  out  high only in RUN
//   lock_lost  out  one-cycle pulse on a lock drop in RELEASE or RUN
//   retry_cnt  out  [8] timeout retries since rst_in, saturating
module mmcm_rst_seq #(
    parameter int NUM_STAGES           = 4,
    parameter int RST_PULSE_CYCLES     = 16,
    parameter int LOCK_FILTER_CYCLES   = 64,
    parameter int RELEASE_STAGE_CYCLES = 8,
    parameter int LOCK_TIMEOUT_CYCLES  = 100000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  mmcm_lock,
    output logic                  mmcm_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  sys_ready,
    output logic                  lock_lost,
    output logic [7:0]            retry_cnt
);

    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_STAGE_CYCLES + 1);
    localparam int SW = $clog2(NUM_STAGES + 1);

    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_STAGE_CYCLES - 1);
    localparam logic [SW-1:0] STG_LAST   = SW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        RESET_MMCM,
        WAIT_LOCK,
        RELEASE,
        RUN
    } state_t;

    state_t        state;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic [PW-1:0] pulse_cnt;
    logic [FW-1:0] filt_cnt;
    logic [RW-1:0] rel_cnt;
    logic [SW-1:0] stg_cnt;
    logic          filt_done;
    logic          tmo_hit;

    assign lock_s = sync_q[1];

    // Filter completes on the cycle that would make the count reach
    // LOCK_FILTER_CYCLES, so RELEASE starts right after the last good sample.
    assign filt_done = (state == WAIT_LOCK) && lock_s && (filt_cnt == FILT_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], mmcm_lock};
    end

`ifdef MMCM_RST_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_LOCK) && (tmo_cnt == TMO_LAST);

    // Held at 0 outside WAIT_LOCK so every attempt starts a fresh window;
    // lock glitches do not touch it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tmo_cnt   <= '0;
            retry_cnt <= 8'd0;
        end else begin
            if (state != WAIT_LOCK || tmo_hit) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + 1'b1;
            // A filter completing on the timeout cycle wins: no retry.
            if (tmo_hit && !filt_done && retry_cnt != 8'd255)
                retry_cnt <= retry_cnt + 8'd1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign retry_cnt = 8'd0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= RESET_MMCM;
            pulse_cnt <= '0;
            filt_cnt  <= '0;
            rel_cnt   <= '0;
            stg_cnt   <= '0;
            mmcm_rst  <= 1'b1;
            rst_out   <= '1;
            sys_ready <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            case (state)
                RESET_MMCM: begin
                    mmcm_rst <= 1'b1;
                    rst_out  <= '1;
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= WAIT_LOCK;
                        pulse_cnt <= '0;
                        filt_cnt  <= '0;
                        mmcm_rst  <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (filt_done) begin
                        state    <= RELEASE;
                        filt_cnt <= '0;
                        rel_cnt  <= '0;
                        stg_cnt  <= '0;
                    end else if (tmo_hit) begin
                        state     <= RESET_MMCM;
                        pulse_cnt <= '0;
                        mmcm_rst  <= 1'b1;
                    end else if (!lock_s) begin
                        filt_cnt <= '0;
                    end else begin
                        filt_cnt <= filt_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state     <= RESET_MMCM;
                        pulse_cnt <= '0;
                        mmcm_rst  <= 1'b1;
                        rst_out   <= '1;
                        lock_lost <= 1'b1;
                    end else if (rel_cnt == REL_LAST) begin
                        rel_cnt <= '0;
                        // Shifting a zero in from the bottom releases stage
                        // 0 first and never re-asserts a released stage.
                        rst_out <= rst_out << 1;
                        if (stg_cnt == STG_LAST) begin
                            state     <= RUN;
                            sys_ready <= 1'b1;
                        end else begin
                            stg_cnt <= stg_cnt + 1'b1;
                        end
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= RESET_MMCM;
                        pulse_cnt <= '0;
                        mmcm_rst  <= 1'b1;
                        rst_out   <= '1;
                        sys_ready <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
                default: begin
                    state     <= RESET_MMCM;
                    pulse_cnt <= '0;
                    mmcm_rst  <= 1'b1;
                    rst_out   <= '1;
                    sys_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_rst_seq.sv
module tb_mmcm_rst_seq;

    localparam int NS = 4;
    localparam int RP = 4;
    localparam int LF = 8;
    localparam int RS = 2;
    localparam int LT = 50;
    localparam int MAXC = 16384;
`ifdef MMCM_RST_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          mmcm_lock = 1'b0;
    logic          mmcm_rst;
    logic [NS-1:0] rst_out;
    logic          sys_ready;
    logic          lock_lost;
    logic [7:0]    retry_cnt;

    int checks = 0;
    int errors = 0;

    // Per-cycle observation/expectation: {mmcm_rst, rst_out[3:0], sys_ready, lock_lost, retry_cnt[7:0]}
    bit          stim  [0:MAXC-1];
    logic [14:0] obs   [0:MAXC-1];
    logic [14:0] exp_v [0:MAXC-1];

    mmcm_rst_seq #(
        .NUM_STAGES(NS), .RST_PULSE_CYCLES(RP), .LOCK_FILTER_CYCLES(LF),
        .RELEASE_STAGE_CYCLES(RS), .LOCK_TIMEOUT_CYCLES(LT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mmcm_lock(mmcm_lock),
        .mmcm_rst(mmcm_rst), .rst_out(rst_out), .sys_ready(sys_ready),
        .lock_lost(lock_lost), .retry_cnt(retry_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Synchronised lock seen by the sequencer on cycle j.
    function automatic bit ls(input int j);
        return (j >= 2) ? stim[j-2] : 1'b0;
    endfunction

    // Reference model: phases tracked by start cycle, outputs derived from
    // elapsed time in the phase. Phase 0 reset pulse, 1 wait, 2 release, 3 run.
    function automatic void model(input int n);
        int ph, s, rty;
        bit lost, ok;
        logic [3:0] ro;
        ph = 0; s = 0; rty = 0;
        for (int c = 0; c < n; c++) begin
            lost = 1'b0;
            if (c > 0) begin
                case (ph)
                    0: if (c - s == RP) begin ph = 1; s = c; end
                    1: begin
                        ok = (c - LF >= s);
                        for (int j = c - LF; j < c; j++) if (ok && !ls(j)) ok = 1'b0;
                        if (ok) begin ph = 2; s = c; end
                        else if (TO_EN && c - s == LT) begin
                            ph = 0; s = c;
                            if (rty < 255) rty++;
                        end
                    end
                    2: if (!ls(c-1)) begin ph = 0; s = c; lost = 1'b1; end
                       else if (c - s == RS*NS) begin ph = 3; s = c; end
                    default: if (!ls(c-1)) begin ph = 0; s = c; lost = 1'b1; end
                endcase
            end
            for (int k = 0; k < NS; k++)
                ro[k] = (ph < 2) ? 1'b1 : (ph == 2) ? ((c - s) < RS*(k+1)) : 1'b0;
            exp_v[c] = {ph == 0, ro, ph == 3, lost, 8'(rty)};
        end
    endfunction

    task automatic do_reset();
        rst_in = 1'b1;
        mmcm_lock = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    // Resets, then plays stim[0..n-1]; cycle 0 is the first with rst_in low.
    task automatic sim(input int n);
        do_reset();
        for (int c = 0; c < n; c++) begin
            mmcm_lock = stim[c];
            @(negedge clk_in);
            obs[c] = {mmcm_rst, rst_out, sys_ready, lock_lost, retry_cnt};
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic fill(input int n, input int rise, input int fall_at, input int fall_len);
        for (int c = 0; c < n; c++)
            stim[c] = (c >= rise) && !(c >= fall_at && c < fall_at + fall_len);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if ({mmcm_rst, rst_out, sys_ready, lock_lost, retry_cnt} !== 15'h7C00) begin
            errors++;
            $display("FAIL reset_values: got %h want 7c00", {mmcm_rst, rst_out, sys_ready, lock_lost, retry_cnt});
        end
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({mmcm_rst, rst_out, sys_ready, lock_lost, retry_cnt} !== 15'h7C00) begin
            errors++;
            $display("FAIL reset_cycle0: got %h want 7c00", {mmcm_rst, rst_out, sys_ready, lock_lost, retry_cnt});
        end
    endtask

    task automatic test_nominal();
        int n = 40;
        fill(n, 10, n, 0);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL nominal cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
        end
        checks++;
        if (obs[3][14] !== 1'b1 || obs[4][14] !== 1'b0) begin
            errors++; $display("FAIL nominal_mmcm_rst: got %b%b want 10", obs[3][14], obs[4][14]);
        end
        checks++;
        if ({obs[21][13:10], obs[22][13:10], obs[24][13:10], obs[26][13:10], obs[28][13:10]} !== 20'hFEC80) begin
            errors++; $display("FAIL nominal_stages: got %h want fec80",
                {obs[21][13:10], obs[22][13:10], obs[24][13:10], obs[26][13:10], obs[28][13:10]});
        end
        checks++;
        if (obs[27][9] !== 1'b0 || obs[28][9] !== 1'b1) begin
            errors++; $display("FAIL nominal_sys_ready: got %b%b want 01", obs[27][9], obs[28][9]);
        end
    endtask

    task automatic test_glitch();
        int n = 45;
        fill(n, 10, 15, 1);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL glitch cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
        end
        // The low sample reaches lock_s at 17; a fresh run of 8 starts at 18,
        // so RELEASE begins at 26 and stage 0 drops at 28.
        checks++;
        if (obs[27][10] !== 1'b1 || obs[28][10] !== 1'b0) begin
            errors++; $display("FAIL glitch_release: got %b%b want 10", obs[27][10], obs[28][10]);
        end
    endtask

    task automatic test_loss_release();
        int n = 50;
        fill(n, 10, 21, n);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL loss_rel cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
        end
        checks++;
        if (obs[23][13:8] !== 6'b1110_0_0 || obs[24][13:8] !== 6'b1111_0_1 || obs[25][8] !== 1'b0) begin
            errors++; $display("FAIL loss_rel_spot: got %b %b %b want 111000 111101 0", obs[23][13:8], obs[24][13:8], obs[25][8]);
        end
    endtask

    task automatic test_loss_run();
        int n = 80;
        fill(n, 10, 35, 5);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL loss_run cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
        end
        checks++;
        if (obs[37][13:8] !== 6'b0000_1_0 || obs[38][13:8] !== 6'b1111_0_1 || obs[39][8] !== 1'b0) begin
            errors++; $display("FAIL loss_run_spot: got %b %b %b want 000010 111101 0", obs[37][13:8], obs[38][13:8], obs[39][8]);
        end
        checks++;
        if ({obs[37][14], obs[38][14], obs[41][14], obs[42][14]} !== 4'b0110) begin
            errors++; $display("FAIL loss_run_mmcm_rst: got %b want 0110", {obs[37][14], obs[38][14], obs[41][14], obs[42][14]});
        end
    endtask

    // Lock arrives so the filter completes exactly on the timeout cycle.
    task automatic test_filter_vs_timeout();
        int n = 70;
        fill(n, 44, n, 0);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL tie cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
        end
        checks++;
        if (obs[54][14] !== 1'b0 || obs[54][7:0] !== 8'd0 || obs[55][13:10] !== 4'hF || obs[56][13:10] !== 4'hE) begin
            errors++; $display("FAIL tie_spot: got %b %0d %h %h want 0 0 f e", obs[54][14], obs[54][7:0], obs[55][13:10], obs[56][13:10]);
        end
    endtask

    task automatic test_random();
        int n = 400;
        for (int it = 0; it < 4; it++) begin
            int c = 0;
            bit v = 1'b0;
            while (c < n) begin
                int len = v ? $urandom_range(1, 40) : $urandom_range(1, 30);
                for (int k = 0; k < len && c < n; k++) begin stim[c] = v; c++; end
                v = ~v;
            end
            sim(n); model(n);
            for (int j = 0; j < n; j++) begin
                checks++;
                if (obs[j] !== exp_v[j]) begin errors++; $display("FAIL random%0d cyc %0d: got %h want %h", it, j, obs[j], exp_v[j]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 74;
        fill(n, 60, n, 0);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL midrst cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
        end
        // Cycle 74 is in RELEASE; pulse rst_in there.
        rst_in = 1'b1;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            checks++;
            if ({mmcm_rst, rst_out, sys_ready, lock_lost, retry_cnt} !== {c < RP, 4'hF, 2'b00, 8'd0}) begin
                errors++; $display("FAIL midrst_after cyc %0d: got %h want %h", c,
                    {mmcm_rst, rst_out, sys_ready, lock_lost, retry_cnt}, {c < RP, 4'hF, 2'b00, 8'd0});
            end
            @(posedge clk_in);
            #1;
        end
    endtask

`ifdef MMCM_RST_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n = 256*54 + 5;
        fill(n, n, n, 0);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL timeout cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
        end
        checks++;
        if (obs[53][14] !== 1'b0 || obs[54][14] !== 1'b1 || obs[54][7:0] !== 8'd1 || obs[108][7:0] !== 8'd2) begin
            errors++; $display("FAIL timeout_spot: got %b %b %0d %0d want 0 1 1 2", obs[53][14], obs[54][14], obs[54][7:0], obs[108][7:0]);
        end
        checks++;
        if (obs[255*54-1][7:0] !== 8'd254 || obs[255*54][7:0] !== 8'd255 || obs[256*54][7:0] !== 8'd255 || obs[256*54][14] !== 1'b1) begin
            errors++; $display("FAIL timeout_sat: got %0d %0d %0d %b want 254 255 255 1",
                obs[255*54-1][7:0], obs[255*54][7:0], obs[256*54][7:0], obs[256*54][14]);
        end
    endtask
`else
    task automatic test_no_timeout();
        int n = 1000;
        int bad = 0;
        fill(n, n, n, 0);
        sim(n); model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL notimeout cyc %0d: got %h want %h", c, obs[c], exp_v[c]); end
            if (c >= RP && (obs[c][14] !== 1'b0 || obs[c][7:0] !== 8'd0)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL notimeout_hold: got %0d bad cycles want 0", bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_loss_release();
        test_loss_run();
        test_filter_vs_timeout();
        test_random();
        test_mid_reset();
`ifdef MMCM_RST_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
